// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// UART transmit stage fed by the AXI-Lite register slave. Takes one byte per
// valid/ready handshake and sends it as: start bit, data LSB first, optional
// parity bit, then 1 or 2 stop bits. Every bit lasts DIV clock cycles.
// o_user_tx_ready going high again tells the slave the byte has been sent.
// All outputs come straight from registers.

module uart_tx_serializer #(
    parameter int P_CLK_FREQ   = 50000000,
    parameter int P_BAUD_RATE  = 115200,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_PARITY     = 0,
    parameter int P_STOP_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_user_tx_valid,
    input  logic [P_DATA_WIDTH-1:0] i_user_tx_data,
    output logic                    o_user_tx_ready,
    output logic                    o_uart_tx,
    output logic                    o_tx_busy
);

    // Clock cycles per bit. The divide truncates, and DIV is assumed to be at least 4.
    localparam int DIV    = P_CLK_FREQ / P_BAUD_RATE;
    localparam int BAUD_W = $clog2(DIV);
    // The bit counter counts data bits, and it is reused to count stop bits.
    localparam int BIT_W  = (P_DATA_WIDTH > 2) ? $clog2(P_DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(P_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(P_STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q;
    logic [BAUD_W-1:0]       baudCnt_q;
    logic [BIT_W-1:0]        bitCnt_q;
    logic [P_DATA_WIDTH-1:0] shift_q;
    logic                    parity_q;
    logic                    armed_q;
    logic                    tx_q;
    logic                    ready_q;
    logic                    busy_q;

    logic                    baudDone;
    logic                    accept;
    logic                    parity_d;

    // Decode the end of a bit period, the handshake, and the parity of the incoming byte
    always_comb begin
        baudDone = (baudCnt_q == BAUD_LAST);
        accept   = (state_q == ST_IDLE) & i_user_tx_valid & ready_q & armed_q;
        parity_d = (P_PARITY == 1) ? ~(^i_user_tx_data) : (^i_user_tx_data);
    end

    // Frame sequencer. armed_q stops a valid that is still high from being taken twice.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            armed_q   <= 1'b1;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            if (!i_user_tx_valid) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    baudCnt_q <= '0;
                    bitCnt_q  <= '0;
                    if (accept) begin
                        shift_q  <= i_user_tx_data;
                        parity_q <= parity_d;
                        armed_q  <= 1'b0;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end

                ST_START: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        bitCnt_q  <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end

                ST_DATA: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        if (bitCnt_q == DATA_LAST) begin
                            bitCnt_q <= '0;
                            if (P_PARITY != 0) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + BIT_ONE;
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end

                ST_PARITY: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        bitCnt_q  <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= ST_STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end

                ST_STOP: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        if (bitCnt_q == STOP_LAST) begin
                            bitCnt_q <= '0;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            bitCnt_q <= bitCnt_q + BIT_ONE;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = ready_q;
    assign o_tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Drives four serializer instances that share DIV = 10. Instance 0 has no
// parity and 1 stop bit, instance 1 even parity, instance 2 odd parity, and
// instance 3 no parity with 2 stop bits. Each accepted byte is queued on a
// scoreboard. A per-instance monitor captures the line for every frame and
// compares it cycle by cycle against a frame built from the queued byte.

module tb_uart_tx_serializer;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int PAR_OF  [4] = '{0, 2, 1, 0};
    localparam int STOP_OF [4] = '{1, 1, 1, 2};

    typedef struct {
        int         idx;
        logic [7:0] data;
    } expItem_t;

    logic       clk;
    logic [3:0] rst;
    logic [3:0] valid;
    logic [7:0] txData [4];
    logic [3:0] ready;
    logic [3:0] tx;
    logic [3:0] busy;

    expItem_t sb[$];
    int       checkCount;
    int       errorCount;
    int       cyc;
    int       frameCount [4];
    int       startCyc   [4];
    int       endCyc     [4];

    // Free-running clock with a period of 10 time units
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used to time frame boundaries
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One DUT per parity/stop configuration, each with its own frame monitor
    for (genvar g = 0; g < 4; g++) begin : gDut
        uart_tx_serializer #(
            .P_CLK_FREQ  (CLK_FREQ),
            .P_BAUD_RATE (BAUD_RATE),
            .P_DATA_WIDTH(8),
            .P_PARITY    (PAR_OF[g]),
            .P_STOP_BITS (STOP_OF[g])
        ) dut (
            .i_clk          (clk),
            .i_rst          (rst[g]),
            .i_user_tx_valid(valid[g]),
            .i_user_tx_data (txData[g]),
            .o_user_tx_ready(ready[g]),
            .o_uart_tx      (tx[g]),
            .o_tx_busy      (busy[g])
        );

        initial forever monitorFrame(g);
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Capture one frame from ready falling to ready rising, then check it against the scoreboard
    task automatic monitorFrame(input int idx);
        logic       lineLog[$];
        logic       expBits[$];
        bit         aborted;
        bit         busyBad;
        int         len;
        int         expLen;
        int         badCycles;
        int         ones;
        logic [7:0] rxByte;
        expItem_t   item;

        do @(negedge clk); while (ready[idx] !== 1'b0);
        startCyc[idx] = cyc;
        aborted = 1'b0;
        busyBad = 1'b0;
        len     = 0;
        forever begin
            if (rst[idx] === 1'b1) aborted = 1'b1;
            if (busy[idx] === ready[idx]) busyBad = 1'b1;
            if (ready[idx] === 1'b1 || len > 1000) break;
            lineLog.push_back(tx[idx]);
            len++;
            @(negedge clk);
        end
        endCyc[idx] = cyc;
        if (aborted) return;

        frameCount[idx]++;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd1, 32'd0);
            return;
        end
        item = sb.pop_front();
        checkOutput("sb_instance", idx, item.idx);

        expBits.push_back(1'b0);
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            expBits.push_back(item.data[k]);
            ones += int'(item.data[k]);
        end
        if (PAR_OF[idx] == 2) expBits.push_back(ones % 2 == 1);
        else if (PAR_OF[idx] == 1) expBits.push_back(ones % 2 == 0);
        for (int s = 0; s < STOP_OF[idx]; s++) expBits.push_back(1'b1);
        expLen = expBits.size() * DIV;

        checkOutput("frame_len", len, expLen);
        badCycles = 0;
        for (int i = 0; i < len && i < expLen; i++) begin
            if (lineLog[i] !== expBits[i / DIV]) badCycles++;
        end
        checkOutput("line_cycles", badCycles, 0);

        rxByte = '0;
        if (len >= 9 * DIV) begin
            for (int k = 0; k < 8; k++) rxByte[k] = lineLog[(k + 1) * DIV + DIV / 2];
        end
        checkOutput("rx_data", rxByte, item.data);
        if (PAR_OF[idx] != 0 && len > 9 * DIV + DIV / 2) begin
            checkOutput("parity_bit", lineLog[9 * DIV + DIV / 2], expBits[9]);
        end
        checkOutput("busy_inverse", busyBad, 0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte to an idle instance and confirm it is taken on the next edge.
    // Afterwards, change the data to show that the frame in flight ignores it.
    task automatic applyStimulus(input int idx, input logic [7:0] d, input bit push);
        if (push) sb.push_back('{idx, d});
        txData[idx] = d;
        valid[idx]  = 1'b1;
        @(negedge clk);
        checkOutput("accept_ready_low", ready[idx], 1'b0);
        checkOutput("accept_busy_high", busy[idx], 1'b1);
        checkOutput("accept_start_bit", tx[idx], 1'b0);
        txData[idx] = ~d;
        valid[idx]  = 1'b0;
    endtask

    // Wait, within a cycle budget, for ready to return high
    task automatic waitIdle(input int idx, input int budget);
        int n;
        n = 0;
        while (ready[idx] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ready[idx] !== 1'b1) checkOutput("idle_timeout", ready[idx], 1'b1);
    endtask

    // Safety net in case a directed sequence stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        bit stayed;
        int n;

        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 4; i++) begin
            frameCount[i] = 0;
            startCyc[i]   = 0;
            endCyc[i]     = 0;
            txData[i]     = 8'h00;
        end
        rst   = 4'hF;
        valid = 4'h0;

        // Reset state, and reset beating a simultaneous valid
        waitCycles(3);
        checkOutput("rst_tx", tx[0], 1'b1);
        checkOutput("rst_ready", ready[0], 1'b1);
        checkOutput("rst_busy", busy[0], 1'b0);
        checkOutput("rst_ready_i3", ready[3], 1'b1);
        valid[0]  = 1'b1;
        txData[0] = 8'hAA;
        waitCycles(2);
        checkOutput("rst_wins_ready", ready[0], 1'b1);
        checkOutput("rst_wins_tx", tx[0], 1'b1);
        valid[0] = 1'b0;
        waitCycles(1);
        rst = 4'h0;
        waitCycles(2);
        checkOutput("post_rst_idle", ready[0], 1'b1);

        // Single byte with no parity
        applyStimulus(0, 8'h55, 1'b1);
        waitIdle(0, 200);
        waitCycles(3);

        // Even and odd parity on 0x07
        applyStimulus(1, 8'h07, 1'b1);
        waitIdle(1, 200);
        waitCycles(3);
        applyStimulus(2, 8'h07, 1'b1);
        waitIdle(2, 200);
        waitCycles(3);

        // Two stop bits
        applyStimulus(3, 8'hA3, 1'b1);
        waitIdle(3, 200);
        waitCycles(3);

        // Valid held through the ready rise: only one frame
        sb.push_back('{0, 8'h3C});
        txData[0] = 8'h3C;
        valid[0]  = 1'b1;
        @(negedge clk);
        checkOutput("held_accept", ready[0], 1'b0);
        waitIdle(0, 200);
        stayed = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready[0] !== 1'b1 || tx[0] !== 1'b1) stayed = 1'b0;
        end
        checkOutput("held_no_reaccept", stayed, 1'b1);

        // Drop valid for one cycle, then re-assert to re-arm
        valid[0] = 1'b0;
        @(negedge clk);
        sb.push_back('{0, 8'h3C});
        valid[0] = 1'b1;
        @(negedge clk);
        checkOutput("rearm_accept", ready[0], 1'b0);
        checkOutput("rearm_start", tx[0], 1'b0);
        valid[0] = 1'b0;
        waitIdle(0, 200);
        waitCycles(3);

        // Back-to-back: next byte offered during the stop bit
        applyStimulus(0, 8'h5A, 1'b1);
        waitCycles(92);
        sb.push_back('{0, 8'h81});
        txData[0] = 8'h81;
        valid[0]  = 1'b1;
        n = 0;
        while (ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_idle_ready", ready[0], 1'b1);
        checkOutput("b2b_idle_high", tx[0], 1'b1);
        @(negedge clk);
        checkOutput("b2b_first_idle_accept", ready[0], 1'b0);
        checkOutput("b2b_start_bit", tx[0], 1'b0);
        valid[0] = 1'b0;
        waitCycles(2);
        checkOutput("b2b_gap", startCyc[0] - endCyc[0], 1);
        waitIdle(0, 200);
        waitCycles(3);

        // Reset during data bit 3 of 0xF0 abandons the frame
        applyStimulus(0, 8'hF0, 1'b0);
        waitCycles(44);
        rst[0] = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx", tx[0], 1'b1);
        checkOutput("midrst_ready", ready[0], 1'b1);
        checkOutput("midrst_busy", busy[0], 1'b0);
        @(negedge clk);
        rst[0] = 1'b0;
        waitCycles(2);
        applyStimulus(0, 8'h12, 1'b1);
        waitIdle(0, 200);
        waitCycles(3);

        // Every queued byte must have been seen exactly once
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("frames_i0", frameCount[0], 6);
        checkOutput("frames_i1", frameCount[1], 1);
        checkOutput("frames_i2", frameCount[2], 1);
        checkOutput("frames_i3", frameCount[3], 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the AXI-Lite register slave.
- Consumes the slave's user TX byte/valid pair and returns a ready level whose rising edge tells the slave a byte has been sent.
- Serializes each accepted byte onto the TX pin as: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
- Bit timing comes from an internal baud divider.

Parameters:
- P_CLK_FREQ, 50000000, input clock frequency in Hz.
- P_BAUD_RATE, 115200, line rate in bit/s. DIV = P_CLK_FREQ / P_BAUD_RATE, integer truncated. DIV >= 4 is required and is not checked in RTL.
- P_DATA_WIDTH, 8, data bits per frame; equals `UART_DATA_WIDTH.
- P_PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- P_STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- i_user_tx_valid  in  1  byte available. Held by upstream until it sees a ready rising edge.
- i_user_tx_data  in  P_DATA_WIDTH  byte to send. Sampled only on acceptance.
- o_user_tx_ready  out  1  high when idle and able to accept; low while a frame is in flight.
- o_uart_tx  out  1  serial line, idle high.
- o_tx_busy  out  1  high from the cycle after acceptance until the frame ends. Always the inverse of o_user_tx_ready.

Behaviour:
- Reset values:
  - o_uart_tx = 1, o_user_tx_ready = 1, o_tx_busy = 0.
  - State = IDLE; baud counter = 0; bit counter = 0; armed = 1; shift register = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Acceptance happens in IDLE when i_user_tx_valid & o_user_tx_ready & armed.
  - armed clears on acceptance.
  - armed sets in any cycle where i_user_tx_valid = 0.
  - Effect: valid must drop between bytes. A valid still high in the cycle ready re-rises is not re-accepted.
- On an acceptance edge at cycle N:
  - Shift register, and the parity bit if enabled, are loaded at N.
  - From N+1: o_uart_tx = 0 (start bit), o_user_tx_ready = 0, o_tx_busy = 1, state = START.
- Baud counter:
  - Counts 0..DIV-1 and restarts at 0 on each state/bit change.
  - Every bit, including start, parity and stop, lasts exactly DIV cycles.
- State machine (each transition occurs when the baud counter reaches DIV-1):
  - IDLE -> START on acceptance.
  - START -> DATA. o_uart_tx = data[0].
  - DATA: shift right each bit period. After bit P_DATA_WIDTH-1, go to PARITY if P_PARITY != 0, else STOP.
  - PARITY: o_uart_tx = parity bit. Even = XOR of data bits; odd = its inverse. Then -> STOP.
  - STOP: o_uart_tx = 1 for P_STOP_BITS*DIV cycles. Then -> IDLE, with o_user_tx_ready = 1 and o_tx_busy = 0 from the next cycle.
- Frame length from first start-bit cycle to ready re-rise = (1 + P_DATA_WIDTH + (P_PARITY != 0) + P_STOP_BITS) * DIV cycles.
- Minimum gap between frames: one idle-high cycle (the acceptance cycle in IDLE).
- Boundary conditions:
  - Valid rising while busy: armed is already set, so the byte is accepted in the first IDLE cycle.
  - Valid high and held through the ready re-rise: no second frame until valid has been low for at least one cycle.
  - i_user_tx_data changes mid-frame: no effect on the frame in flight.
  - Reset mid-frame: next cycle o_uart_tx = 1, ready = 1, state = IDLE. The partial frame is abandoned; no completion edge other than the ready rise.
  - Reset asserted together with valid: reset wins; nothing is accepted.

Test Plan:
Bench parameters: P_CLK_FREQ = 1000000, P_BAUD_RATE = 100000, so DIV = 10.
- Single byte: P_PARITY = 0, send 0x55 (pulse valid, drop after the ready edge).
  - Expected: line reads 0,1,0,1,0,1,0,1,0,1 at 10-cycle intervals.
  - Ready low for exactly 100 cycles, starting the cycle after acceptance.
- Even parity: send 0x07.
  - Expected: 8 data bits 1,1,1,0,0,0,0,0, then parity = 1, then stop.
  - Frame is 110 cycles. Odd-parity rerun gives parity = 0.
- Two stop bits: send 0xA3 with P_STOP_BITS = 2.
  - Expected: line high for 20 cycles after bit 7; ready rises at cycle 110.
- Held valid: keep valid = 1 with data 0x3C across the ready re-rise.
  - Expected: exactly one frame; line stays high.
  - Then drop valid for 1 cycle and reassert: a second frame of 0x3C starts 1 cycle after re-acceptance.
- Back-to-back: assert valid with 0x81 while the previous frame's stop bit is active.
  - Expected: accepted in the first IDLE cycle; next start bit follows the previous stop bit after exactly 1 idle-high cycle.
- Reset mid-frame: assert i_rst at data bit 3 of 0xF0.
  - Expected: next cycle line = 1, ready = 1, busy = 0.
  - A subsequent send of 0x12 produces a clean 100-cycle frame.
